// File: rtl/exp_ctrl.sv
// Experiment sequencer: primes the rng -> div_3 -> sum_3 datapath, accumulates
// TRIALS samples per experiment and reports sum/mean/index for NUM_EXP experiments.
module exp_ctrl #(
    parameter int DATA_W   = 8,
    parameter int TRIALS   = 16,
    parameter int NUM_EXP  = 11,
    parameter int PIPE_LAT = 3,
    parameter int ACC_W    = 12
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_W-1:0]           sum_val,
    output logic                        rng_en,
    output logic                        busy,
    output logic                        exp_valid,
    output logic [3:0]                  exp_idx,
    output logic [ACC_W-1:0]            exp_sum,
    output logic [DATA_W-1:0]           exp_mean,
    output logic [$clog2(TRIALS):0]     trial_cnt,
    output logic                        done,
    output logic [2:0]                  state_dbg
);

    localparam int LOG_T = $clog2(TRIALS);
    localparam int PW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    generate
        if (ACC_W < DATA_W + LOG_T) begin : g_acc_too_narrow
            $error("exp_ctrl: ACC_W must be at least DATA_W + log2(TRIALS)");
        end
        if ((1 << LOG_T) != TRIALS || TRIALS < 2) begin : g_trials_bad
            $error("exp_ctrl: TRIALS must be a power of two and at least 2");
        end
        if (NUM_EXP < 1 || NUM_EXP > 16) begin : g_num_exp_bad
            $error("exp_ctrl: NUM_EXP must be in 1..16");
        end
        if (PIPE_LAT < 1) begin : g_pipe_lat_bad
            $error("exp_ctrl: PIPE_LAT must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_RUN   = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  start_q;
    logic                  armed_q;
    logic [PW-1:0]         prime_q;
    logic [ACC_W-1:0]      acc_q;
    logic [3:0]            idx_q;
    logic                  start_rise;
    logic                  last_trial;
    logic                  last_exp;

    // armed_q blocks a start that is already high when reset releases from
    // being mistaken for a rising edge.
    assign start_rise = start & ~start_q & armed_q;
    assign last_trial = (trial_cnt == ($clog2(TRIALS)+1)'(TRIALS - 1));
    assign last_exp   = (idx_q == 4'(NUM_EXP - 1));

    // exp_valid is a bare one-cycle strobe with no ready: consumers must
    // capture exp_idx/exp_sum/exp_mean in the cycle it is high.
    assign busy      = (state_q == S_PRIME) || (state_q == S_RUN) || (state_q == S_EMIT);
    assign rng_en    = busy;
    assign done      = (state_q == S_DONE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_rise) state_d = S_PRIME;
            S_PRIME: begin
                if (!start)                             state_d = S_IDLE;
                else if (prime_q == PW'(PIPE_LAT - 1))  state_d = S_RUN;
            end
            S_RUN: begin
                if (!start)          state_d = S_IDLE;
                else if (last_trial) state_d = S_EMIT;
            end
            S_EMIT: begin
                if (!start)        state_d = S_IDLE;
                else if (last_exp) state_d = S_DONE;
                else               state_d = S_RUN;
            end
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            armed_q   <= 1'b0;
            prime_q   <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            trial_cnt <= '0;
            exp_valid <= 1'b0;
            exp_idx   <= '0;
            exp_sum   <= '0;
            exp_mean  <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start;
            if (!start) armed_q <= 1'b1;
            exp_valid <= 1'b0;
            prime_q   <= (state_q == S_PRIME) ? prime_q + 1'b1 : '0;

            case (state_q)
                S_IDLE: begin
                    acc_q     <= '0;
                    trial_cnt <= '0;
                    if (start_rise) idx_q <= '0;
                end
                S_RUN: begin
                    if (start) begin
                        acc_q     <= acc_q + ACC_W'(sum_val);
                        trial_cnt <= trial_cnt + 1'b1;
                    end else begin
                        acc_q     <= '0;
                        trial_cnt <= '0;
                    end
                end
                S_EMIT: begin
                    // The sample presented during EMIT is intentionally dropped.
                    acc_q     <= '0;
                    trial_cnt <= '0;
                    if (start) begin
                        exp_sum   <= acc_q;
                        exp_mean  <= DATA_W'(acc_q >> LOG_T);
                        exp_idx   <= idx_q;
                        exp_valid <= 1'b1;
                        if (!last_exp) idx_q <= idx_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exp_ctrl.sv
// Bench for exp_ctrl: directed sequence of runs with constant, ramp and random
// samples, checked against expected sums computed from the sample table.
module tb_exp_ctrl;

    localparam int DATA_W    = 8;
    localparam int TRIALS    = 16;
    localparam int NUM_EXP   = 11;
    localparam int PIPE_LAT  = 3;
    localparam int ACC_W     = 12;
    localparam int FIRST_RUN = 1 + PIPE_LAT;
    localparam int PERIOD    = TRIALS + 1;
    localparam int RUN_LEN   = 1 + PIPE_LAT + NUM_EXP * PERIOD;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [DATA_W-1:0]   sum_val;
    logic                rng_en;
    logic                busy;
    logic                exp_valid;
    logic [3:0]          exp_idx;
    logic [ACC_W-1:0]    exp_sum;
    logic [DATA_W-1:0]   exp_mean;
    logic [4:0]          trial_cnt;
    logic                done;
    logic [2:0]          state_dbg;

    int errors = 0;
    int checks = 0;
    int vals[0:255];
    logic [ACC_W-1:0] exp_q[$];

    // clock/reset block
    always #5 clk = ~clk;

    exp_ctrl #(
        .DATA_W(DATA_W), .TRIALS(TRIALS), .NUM_EXP(NUM_EXP),
        .PIPE_LAT(PIPE_LAT), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sum_val(sum_val),
        .rng_en(rng_en), .busy(busy), .exp_valid(exp_valid),
        .exp_idx(exp_idx), .exp_sum(exp_sum), .exp_mean(exp_mean),
        .trial_cnt(trial_cnt), .done(done), .state_dbg(state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rng_en"},    32'(rng_en),    32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_exp_valid"}, 32'(exp_valid), 32'd0);
        check({tag, "_exp_idx"},   32'(exp_idx),   32'd0);
        check({tag, "_exp_sum"},   32'(exp_sum),   32'd0);
        check({tag, "_exp_mean"},  32'(exp_mean),  32'd0);
        check({tag, "_trial_cnt"}, 32'(trial_cnt), 32'd0);
        check({tag, "_done"},      32'(done),      32'd0);
    endtask

    // kind: 0 = const 5, 1 = const 255, 2 = ramp from first RUN cycle, 3 = random.
    // abort_c < 0 runs to completion; otherwise start drops in that cycle.
    task automatic do_run(input int kind, input int abort_c);
        bit full;
        bit busy_exp, done_exp, valid_exp;
        int n_rep, rep_i, s, last_c, trial_exp;
        logic [ACC_W-1:0] want;
        full = (abort_c < 0);
        for (int c = 0; c < 256; c++) begin
            case (kind)
                0:       vals[c] = 5;
                1:       vals[c] = 255;
                2:       vals[c] = (c >= FIRST_RUN) ? ((c - FIRST_RUN) % 256) : 0;
                default: vals[c] = int'($urandom_range(0, 255));
            endcase
        end
        n_rep = 0;
        for (int e = 0; e < NUM_EXP; e++)
            if (full || (FIRST_RUN + e * PERIOD + TRIALS < abort_c)) n_rep++;
        exp_q.delete();
        for (int e = 0; e < n_rep; e++) begin
            s = 0;
            for (int t = 0; t < TRIALS; t++) s += vals[FIRST_RUN + e * PERIOD + t];
            exp_q.push_back(ACC_W'(s));
        end
        last_c = full ? RUN_LEN + 1 : abort_c + 3;
        rep_i  = 0;
        for (int c = 0; c <= last_c; c++) begin
            @(negedge clk);
            busy_exp  = full ? (c >= 1 && c < RUN_LEN) : (c >= 1 && c <= abort_c);
            done_exp  = full && (c >= RUN_LEN);
            valid_exp = (c >= FIRST_RUN + PERIOD) && ((c - FIRST_RUN - PERIOD) % PERIOD == 0)
                        && ((c - FIRST_RUN - PERIOD) / PERIOD < n_rep);
            trial_exp = (busy_exp && c >= FIRST_RUN) ? (c - FIRST_RUN) % PERIOD : 0;
            check("busy",      32'(busy),      32'(busy_exp));
            check("rng_en",    32'(rng_en),    32'(busy_exp));
            check("done",      32'(done),      32'(done_exp));
            check("exp_valid", 32'(exp_valid), 32'(valid_exp));
            check("trial_cnt", 32'(trial_cnt), 32'(trial_exp));
            if (exp_valid && exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("exp_sum",  32'(exp_sum),  32'(want));
                check("exp_mean", 32'(exp_mean), 32'(want / TRIALS));
                check("exp_idx",  32'(exp_idx),  32'(rep_i));
                rep_i++;
            end
            if (c == 0) start = 1'b1;
            if (!full && c == abort_c) start = 1'b0;
            sum_val = vals[c][7:0];
        end
        check("reports_left", 32'(exp_q.size()), 32'd0);
        check("idx_held",     32'(exp_idx),      32'(n_rep - 1));
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("end_done",  32'(done),      32'd0);
        check("end_busy",  32'(busy),      32'd0);
        check("end_state", 32'(state_dbg), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        sum_val = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_state",  32'(state_dbg), 32'd0);
            check("idle_rng_en", 32'(rng_en),    32'd0);
            check("idle_busy",   32'(busy),      32'd0);
        end

        do_run(0, -1);
        do_run(1, -1);
        do_run(2, -1);
        do_run(3, -1);
        // abort in exp 3 at trial 7: three reports, then restart from idx 0
        do_run(3, FIRST_RUN + 3 * PERIOD + 7);
        do_run(3, -1);

        // start held high through reset release is not an edge
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("held_start_busy", 32'(busy), 32'd0);
        end

        // reset in PRIME
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        check("prime_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("prime_rst_busy",   32'(busy),   32'd0);
        check("prime_rst_rng_en", 32'(rng_en), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_no_run", 32'(busy), 32'd0);
        end

        // reset deep in RUN
        start = 1'b0;
        @(negedge clk);
        sum_val = 8'd9;
        start   = 1'b1;
        repeat (100) @(negedge clk);
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_rst");
        rst   = 1'b0;
        start = 1'b0;

        // reset while DONE
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        repeat (RUN_LEN) @(negedge clk);
        check("done_at_latency", 32'(done),    32'd1);
        check("done_sum",        32'(exp_sum), 32'(9 * TRIALS));
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("done_rst");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
